// File: rtl/circuit_b.sv
// rtl/circuit_b.sv - 2-bit unsigned magnitude comparator with registered one-hot flags
//
// Compares A = {A1,A0} against B = {B1,B0}, both unsigned 0..3, and registers
// the greater/equal/less result one clock after the operands are sampled.
//
// Ports:
//   F1  out  A > B  (registered)
//   F2  out  A == B (registered)
//   F3  out  A < B  (registered)
//   A0  in   operand A bit 0 (LSB)
//   A1  in   operand A bit 1 (MSB)
//   B0  in   operand B bit 0 (LSB)
//   B1  in   operand B bit 1 (MSB)
//   clk in   clock, rising edge
//   rst in   asynchronous active-high reset; clears all flags

module circuit_b (
   output logic F1,
   output logic F2,
   output logic F3,
   input  logic A0,
   input  logic A1,
   input  logic B0,
   input  logic B1,
   input  logic clk,
   input  logic rst
);

   logic gt_d, eq_d, lt_d;
   logic gt_q, eq_q, lt_q;
   logic msb_eq;

   // MSB decides unless the MSBs match, in which case the LSB decides.
   always_comb begin
      msb_eq = ~(A1 ^ B1);
      gt_d   = (A1 & ~B1) | (msb_eq & A0 & ~B0);
      eq_d   = msb_eq & ~(A0 ^ B0);
      lt_d   = (~A1 & B1) | (msb_eq & ~A0 & B0);
   end

   // All-zero is the "no result yet" code held through reset until the
   // first post-release edge loads a real compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gt_q <= 1'b0;
         eq_q <= 1'b0;
         lt_q <= 1'b0;
      end else begin
         gt_q <= gt_d;
         eq_q <= eq_d;
         lt_q <= lt_d;
      end
   end

   assign F1 = gt_q;
   assign F2 = eq_q;
   assign F3 = lt_q;

endmodule

// File: tb/tb_circuit_b.sv
// tb/tb_circuit_b.sv - directed self-checking bench for circuit_b

module tb_circuit_b;

   logic clk;
   logic rst;
   logic A0, A1, B0, B1;
   logic F1, F2, F3;

   int tests_run;
   int tests_failed;

   // Expected {F1,F2,F3} indexed by A*4+B, worked out by hand.
   logic [2:0] sweep_exp [16];

   circuit_b dut (
      .F1  (F1),
      .F2  (F2),
      .F3  (F3),
      .A0  (A0),
      .A1  (A1),
      .B0  (B0),
      .B1  (B1),
      .clk (clk),
      .rst (rst)
   );

   always #5 clk = ~clk;

   task automatic set_ops(input int a, input int b);
      A1 = a[1];
      A0 = a[0];
      B1 = b[1];
      B0 = b[0];
   endtask

   task automatic test_reset();
      set_ops(3, 0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         tests_run++;
         if ({F1, F2, F3} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_hold[%0d]: got %b expected %b", i, {F1, F2, F3}, 3'b000);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if ({F1, F2, F3} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_release_no_edge: got %b expected %b", {F1, F2, F3}, 3'b000);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if ({F1, F2, F3} !== 3'b100) begin
         tests_failed++;
         $display("FAIL reset_first_edge: got %b expected %b", {F1, F2, F3}, 3'b100);
      end
   endtask

   task automatic test_sweep();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         set_ops(i / 4, i % 4);
         @(posedge clk);
         #1;
         tests_run++;
         if ({F1, F2, F3} !== sweep_exp[i]) begin
            tests_failed++;
            $display("FAIL sweep A=%0d B=%0d: got %b expected %b", i / 4, i % 4, {F1, F2, F3}, sweep_exp[i]);
         end
         tests_run++;
         if ($countones({F1, F2, F3}) != 1) begin
            tests_failed++;
            $display("FAIL onehot A=%0d B=%0d: got %b expected exactly one bit set", i / 4, i % 4, {F1, F2, F3});
         end
      end
   endtask

   task automatic test_latency();
      @(negedge clk);
      set_ops(0, 0);
      @(posedge clk);
      #1;
      tests_run++;
      if ({F1, F2, F3} !== 3'b010) begin
         tests_failed++;
         $display("FAIL latency_setup: got %b expected %b", {F1, F2, F3}, 3'b010);
      end
      @(negedge clk);
      set_ops(3, 1);
      #1;
      tests_run++;
      if ({F1, F2, F3} !== 3'b010) begin
         tests_failed++;
         $display("FAIL latency_hold_midcycle: got %b expected %b", {F1, F2, F3}, 3'b010);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if ({F1, F2, F3} !== 3'b100) begin
         tests_failed++;
         $display("FAIL latency_update: got %b expected %b", {F1, F2, F3}, 3'b100);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      set_ops(2, 0);
      @(posedge clk);
      #1;
      tests_run++;
      if ({F1, F2, F3} !== 3'b100) begin
         tests_failed++;
         $display("FAIL async_pre: got %b expected %b", {F1, F2, F3}, 3'b100);
      end
      #1;
      rst = 1'b1;
      #1;
      tests_run++;
      if ({F1, F2, F3} !== 3'b000) begin
         tests_failed++;
         $display("FAIL async_assert: got %b expected %b", {F1, F2, F3}, 3'b000);
      end
      rst = 1'b0;
      #1;
      tests_run++;
      if ({F1, F2, F3} !== 3'b000) begin
         tests_failed++;
         $display("FAIL async_release_no_edge: got %b expected %b", {F1, F2, F3}, 3'b000);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if ({F1, F2, F3} !== 3'b100) begin
         tests_failed++;
         $display("FAIL async_recover: got %b expected %b", {F1, F2, F3}, 3'b100);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i % 2 == 0) begin
            set_ops(2, 2);
            exp = 3'b010;
         end else begin
            set_ops(0, 3);
            exp = 3'b001;
         end
         @(posedge clk);
         #1;
         tests_run++;
         if ({F1, F2, F3} !== exp) begin
            tests_failed++;
            $display("FAIL back_to_back[%0d]: got %b expected %b", i, {F1, F2, F3}, exp);
         end
      end
   endtask

   initial begin
      sweep_exp[0]  = 3'b010; sweep_exp[1]  = 3'b001; sweep_exp[2]  = 3'b001; sweep_exp[3]  = 3'b001;
      sweep_exp[4]  = 3'b100; sweep_exp[5]  = 3'b010; sweep_exp[6]  = 3'b001; sweep_exp[7]  = 3'b001;
      sweep_exp[8]  = 3'b100; sweep_exp[9]  = 3'b100; sweep_exp[10] = 3'b010; sweep_exp[11] = 3'b001;
      sweep_exp[12] = 3'b100; sweep_exp[13] = 3'b100; sweep_exp[14] = 3'b100; sweep_exp[15] = 3'b010;

      tests_run    = 0;
      tests_failed = 0;
      clk = 1'b0;
      rst = 1'b1;
      set_ops(0, 0);

      test_reset();
      test_sweep();
      test_latency();
      test_async_reset();
      test_back_to_back();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
